// File: rtl/irq_source_arbiter.sv
// Fixed-priority interrupt source arbiter: latches edge/level requests, presents one
// request to the CPU interrupt controller and acknowledges the serviced source on return.
module irq_source_arbiter #(
  parameter int unsigned   N          = 16,
  parameter logic [N-1:0]  EDGE_MASK  = '0,
  parameter logic [31:0]   CAUSE_BASE = 32'h8000_0010
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  irq_lines_i,
  input  logic [N-1:0]  irq_mask_i,
  input  logic          irq_taken_i,
  input  logic          irq_ret_i,
  output logic          irq_req_o,
  output logic [4:0]    irq_id_o,
  output logic [31:0]   irq_cause_o,
  output logic [N-1:0]  irq_ack_o,
  output logic [N-1:0]  pending_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_req;
  logic [4:0]    r_id;
  logic [31:0]   r_cause;
  logic [N-1:0]  r_ack;
  logic [N-1:0]  r_pending;
  logic [N-1:0]  r_hist;

  logic [N-1:0]  w_rise;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_pending_nxt;
  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_id_onehot;
  logic [4:0]    w_sel_id;
  logic          w_any;
  logic          w_ret_fire;

  assign w_rise     = irq_lines_i & ~r_hist;
  assign w_ret_fire = (r_state == ST_SERVICE) && irq_ret_i;
  assign w_clr      = w_ret_fire ? (w_id_onehot & EDGE_MASK) : '0;

  // Edge bits: clear on return, but a rise in the same cycle wins. Level bits mirror the line.
  assign w_pending_nxt = (EDGE_MASK & ((r_pending & ~w_clr) | w_rise))
                       | (~EDGE_MASK & irq_lines_i);

  assign w_elig = r_pending & irq_mask_i;
  assign w_any  = |w_elig;

  // NOTE: every always_comb output gets a default before the loop, otherwise a latch is inferred.
  always_comb begin
    w_sel_id = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel_id = 5'(i);
    end
  end

  always_comb begin
    w_id_onehot = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_id_onehot[i] = (r_id == 5'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hist    <= '0;
      r_pending <= '0;
    end else begin
      r_hist    <= irq_lines_i;
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_id    <= '0;
      r_cause <= CAUSE_BASE;
      r_ack   <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_id    <= w_sel_id;
            r_cause <= CAUSE_BASE + 32'(w_sel_id);
          end
        end
        // Request is frozen here: mask/line changes and higher-priority arrivals are ignored.
        ST_REQ: begin
          if (irq_taken_i) begin
            r_state <= ST_SERVICE;
            r_req   <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (irq_ret_i) begin
            r_ack   <= w_id_onehot;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req_o   = r_req;
  assign irq_id_o    = r_id;
  assign irq_cause_o = r_cause;
  assign irq_ack_o   = r_ack;
  assign pending_o   = r_pending;

endmodule

// File: tb/tb_irq_source_arbiter.sv
// Self-checking bench for irq_source_arbiter: expected requests are queued when
// stimulus is driven and popped when the DUT raises its request.
module tb_irq_source_arbiter;

  localparam logic [31:0] CB = 32'h8000_0010;

  typedef struct {
    logic [4:0]  id;
    logic [31:0] cause;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] irq_lines_i;
  logic [15:0] irq_mask_i;
  logic        irq_taken_i;
  logic        irq_ret_i;
  logic        irq_req_o;
  logic [4:0]  irq_id_o;
  logic [31:0] irq_cause_o;
  logic [15:0] irq_ack_o;
  logic [15:0] pending_o;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  irq_source_arbiter #(
    .N          (16),
    .EDGE_MASK  (16'h003C),
    .CAUSE_BASE (CB)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_lines_i (irq_lines_i),
    .irq_mask_i  (irq_mask_i),
    .irq_taken_i (irq_taken_i),
    .irq_ret_i   (irq_ret_i),
    .irq_req_o   (irq_req_o),
    .irq_id_o    (irq_id_o),
    .irq_cause_o (irq_cause_o),
    .irq_ack_o   (irq_ack_o),
    .pending_o   (pending_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id    = 5'(id);
    e.cause = CB + 32'(id);
    exp_q.push_back(e);
  endtask

  // One full service transaction, checked against the head of the scoreboard.
  task automatic serve_next(input string tag, input logic [15:0] drop_before_ret,
                            input logic [15:0] pulse_with_ret);
    exp_t        e;
    int          waited;
    logic [15:0] exp_ack;
    waited = 0;
    while (irq_req_o !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (irq_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s req_timeout: req=%b required 1", tag, irq_req_o);
      return;
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s sb_empty: unexpected request id=%0d", tag, irq_id_o);
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (irq_id_o !== e.id) begin
      n_err++;
      $display("FAIL %s id: got %0d required %0d", tag, irq_id_o, e.id);
    end
    n_cmp++;
    if (irq_cause_o !== e.cause) begin
      n_err++;
      $display("FAIL %s cause: got %h required %h", tag, irq_cause_o, e.cause);
    end
    irq_taken_i = 1'b1;
    tick();
    irq_taken_i = 1'b0;
    n_cmp++;
    if (irq_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s req_drop: got %b required 0", tag, irq_req_o);
    end
    irq_lines_i = irq_lines_i & ~drop_before_ret;
    tick();
    irq_ret_i   = 1'b1;
    irq_lines_i = irq_lines_i | pulse_with_ret;
    tick();
    irq_ret_i   = 1'b0;
    irq_lines_i = irq_lines_i & ~pulse_with_ret;
    exp_ack = 16'h0001 << e.id;
    n_cmp++;
    if (irq_ack_o !== exp_ack) begin
      n_err++;
      $display("FAIL %s ack: got %h required %h", tag, irq_ack_o, exp_ack);
    end
    tick();
    n_cmp++;
    if (irq_ack_o !== 16'h0000) begin
      n_err++;
      $display("FAIL %s ack_one_cycle: got %h required 0000", tag, irq_ack_o);
    end
  endtask

  task automatic test_reset();
    rst_i       = 1'b0;
    irq_lines_i = '0;
    irq_mask_i  = 16'hFFFF;
    irq_taken_i = 1'b0;
    irq_ret_i   = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({irq_req_o, irq_id_o, irq_ack_o, pending_o} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_vals: req=%b id=%0d ack=%h pend=%h required all 0",
               irq_req_o, irq_id_o, irq_ack_o, pending_o);
    end
    n_cmp++;
    if (irq_cause_o !== CB) begin
      n_err++;
      $display("FAIL reset_cause: got %h required %h", irq_cause_o, CB);
    end
    rst_i = 1'b1;
    tick();
    irq_taken_i = 1'b1;
    tick();
    irq_taken_i = 1'b0;
    n_cmp++;
    if (irq_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL stray_taken: req=%b required 0", irq_req_o);
    end
  endtask

  task automatic test_single_edge();
    irq_lines_i[3] = 1'b1;
    push_exp(3);
    tick();
    irq_lines_i[3] = 1'b0;
    n_cmp++;
    if (irq_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL edge_early_req: got %b required 0", irq_req_o);
    end
    tick();
    n_cmp++;
    if (irq_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL edge_latency: req=%b required 1 two cycles after edge", irq_req_o);
    end
    serve_next("single", 16'h0000, 16'h0000);
    n_cmp++;
    if (pending_o !== 16'h0000) begin
      n_err++;
      $display("FAIL single_pending: got %h required 0000", pending_o);
    end
  endtask

  task automatic test_priority();
    push_exp(2);
    push_exp(5);
    irq_lines_i = 16'h0024;
    tick();
    irq_lines_i = '0;
    serve_next("prio_first", 16'h0000, 16'h0000);
    serve_next("prio_second", 16'h0000, 16'h0000);
    n_cmp++;
    if (pending_o !== 16'h0000) begin
      n_err++;
      $display("FAIL prio_pending: got %h required 0000", pending_o);
    end
  endtask

  task automatic test_masking();
    bit seen_req;
    seen_req       = 1'b0;
    irq_mask_i     = 16'hFFFD;
    irq_lines_i[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (irq_req_o !== 1'b0) seen_req = 1'b1;
    end
    n_cmp++;
    if (seen_req) begin
      n_err++;
      $display("FAIL mask_block: req seen=1 required 0 over 20 cycles");
    end
    n_cmp++;
    if (pending_o[1] !== 1'b1) begin
      n_err++;
      $display("FAIL mask_pending: pend[1]=%b required 1", pending_o[1]);
    end
    push_exp(1);
    irq_mask_i = 16'hFFFF;
    tick();
    n_cmp++;
    if (irq_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL unmask_req: got %b required 1", irq_req_o);
    end
    irq_mask_i = 16'hFFFD;
    repeat (3) tick();
    n_cmp++;
    if (irq_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL mask_in_req: got %b required 1", irq_req_o);
    end
    irq_lines_i[1] = 1'b0;
    serve_next("mask", 16'h0000, 16'h0000);
    irq_mask_i = 16'hFFFF;
    repeat (3) tick();
    n_cmp++;
    if (irq_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL mask_idle: got %b required 0", irq_req_o);
    end
  endtask

  task automatic test_level();
    push_exp(7);
    push_exp(7);
    irq_lines_i[7] = 1'b1;
    serve_next("lvl_hold", 16'h0000, 16'h0000);
    serve_next("lvl_drop", 16'h0080, 16'h0000);
    repeat (3) tick();
    n_cmp++;
    if (irq_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL lvl_no_rereq: got %b required 0", irq_req_o);
    end
  endtask

  task automatic test_set_wins();
    push_exp(4);
    push_exp(4);
    irq_lines_i[4] = 1'b1;
    tick();
    irq_lines_i[4] = 1'b0;
    serve_next("setwin_first", 16'h0000, 16'h0010);
    n_cmp++;
    if (pending_o[4] !== 1'b1) begin
      n_err++;
      $display("FAIL setwin_pending: pend[4]=%b required 1", pending_o[4]);
    end
    serve_next("setwin_second", 16'h0000, 16'h0000);
    n_cmp++;
    if (pending_o !== 16'h0000) begin
      n_err++;
      $display("FAIL setwin_clear: got %h required 0000", pending_o);
    end
  endtask

  task automatic test_async_reset();
    int waited;
    exp_t e;
    push_exp(3);
    irq_lines_i[3] = 1'b1;
    tick();
    irq_lines_i[3] = 1'b0;
    waited = 0;
    while (irq_req_o !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (irq_req_o !== 1'b1 || irq_id_o !== e.id) begin
      n_err++;
      $display("FAIL rst_setup: req=%b id=%0d required 1/%0d", irq_req_o, irq_id_o, e.id);
    end
    irq_taken_i = 1'b1;
    tick();
    irq_taken_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if ({irq_req_o, irq_ack_o, pending_o} !== 33'd0) begin
      n_err++;
      $display("FAIL async_rst: req=%b ack=%h pend=%h required all 0",
               irq_req_o, irq_ack_o, pending_o);
    end
    n_cmp++;
    if (irq_id_o !== 5'd0 || irq_cause_o !== CB) begin
      n_err++;
      $display("FAIL async_rst_id: id=%0d cause=%h required 0/%h", irq_id_o, irq_cause_o, CB);
    end
    tick();
    rst_i = 1'b1;
    tick();
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    n_cmp++;
    if (irq_ack_o !== 16'h0000 || irq_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL stray_ret: ack=%h req=%b required 0000/0", irq_ack_o, irq_req_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_priority();
    test_masking();
    test_level();
    test_set_wins();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d expected requests never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_source_arbiter.md
Name: irq_source_arbiter

Overview:
- Peripheral-side counterpart of the CPU interrupt controller: collects N peripheral interrupt lines, latches pending requests, picks one by fixed priority and drives the single request into the controller.
- Holds the selected source stable until the controller takes the trap, then waits for the return pulse.
- On return, clears the serviced pending bit and pulses a per-source acknowledge back to the peripheral.

Parameters:
- N, 16: number of interrupt sources (1..32).
- EDGE_MASK, 16'h0000: bit i = 1 means source i is rising-edge triggered; 0 means level triggered.
- CAUSE_BASE, 32'h8000_0010: base mcause value; the reported cause is CAUSE_BASE + id.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low (logic 0 resets).
- irq_lines_i  in  N  raw peripheral interrupt lines, synchronous to clk_i.
- irq_mask_i  in  N  per-source enable (software register); 0 blocks selection only.
- irq_taken_i  in  1  one-cycle pulse from the controller: trap entered for the current request.
- irq_ret_i  in  1  one-cycle pulse from the controller: mret from an interrupt handler.
- irq_req_o  out  1  request to the controller.
- irq_id_o  out  5  index of the selected or serviced source.
- irq_cause_o  out  32  CAUSE_BASE + irq_id_o, zero-extended add.
- irq_ack_o  out  N  one-hot, one-cycle acknowledge to the serviced source.
- pending_o  out  N  current pending vector (debug/CSR readback).

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE; pending=0; edge history register=0.
  - irq_req_o=0, irq_id_o=0, irq_cause_o=CAUSE_BASE, irq_ack_o=0.
- Pending bits:
  - Edge source i: pending[i] sets the cycle after lines[i] goes 0->1 (compared against a 1-cycle history flop).
  - Edge source i stays set until cleared by a return.
  - Level source i: pending[i] = registered lines[i]. It is never cleared by the arbiter; the peripheral drops the line after irq_ack_o.
- Selection: the lowest index i with pending[i] & irq_mask_i[i] wins.
- FSM IDLE:
  - If any eligible source exists, latch its index into id and go to REQ.
  - irq_req_o=1 from the next cycle. Latency from edge on the line to irq_req_o is 2 cycles.
- FSM REQ:
  - irq_req_o=1; id is frozen.
  - Changes to irq_mask_i or the lines are ignored; no retraction, no preemption by higher priority.
  - On irq_taken_i, go to SERVICE and drop irq_req_o in the same cycle as the transition.
- FSM SERVICE:
  - irq_req_o=0; id held.
  - On irq_ret_i: pulse irq_ack_o[id] for 1 cycle (registered, so it is visible the cycle after irq_ret_i).
  - Same edge: clear pending[id] if id is an edge source, then go to IDLE.
- irq_ret_i outside SERVICE, or irq_taken_i outside REQ: ignored, no state change.
- Simultaneous set/clear on the same edge source in the same cycle: set wins, so pending stays 1.
- irq_taken_i and irq_ret_i in the same cycle while in REQ: only taken is processed.
- IDLE re-arbitrates the cycle after returning; back-to-back service is allowed.
- Reset asserted mid-REQ/SERVICE: immediate return to reset values, no ack pulse, pending lost.
- irq_cause_o and irq_id_o are registered and track id in all states.

Test Plan:
- Single edge: EDGE_MASK[3]=1, mask=all 1s, pulse lines[3] for 1 cycle.
  - Required: irq_req_o=1 two cycles later, irq_id_o=3, irq_cause_o=32'h8000_0013.
  - taken pulse -> req=0 next cycle. ret pulse -> irq_ack_o=16'h0008 for 1 cycle, pending_o=0.
- Priority: lines[5] and lines[2] rise together.
  - Required: id=2 serviced first; after ret, re-arbitration gives id=5, cause 32'h8000_0015.
- Masking: lines[1] pending with mask[1]=0.
  - Required: irq_req_o stays 0 for 20 cycles. Setting mask[1]=1 -> req within 1 cycle.
  - Clearing mask[1] while in REQ -> req stays 1.
- Level source: lines[7] held high through ret.
  - Required: after ret, irq_ack_o[7] pulses and req re-asserts for id 7.
  - Dropping the line before ret -> no re-request.
- Set-wins: edge source 4 in SERVICE with id=4, new rising edge on lines[4] such that the set lands in the ret cycle.
  - Required: pending_o[4]=1 after ret and a second request is issued.
- Async reset: drive rst_i=0 mid-SERVICE, between clock edges.
  - Required: irq_req_o=0, pending_o=0, irq_ack_o=0 immediately, before the next clock edge.
  - Stray ret after release -> no ack.
